psram_arbiter: RTL and testbench

- Shares the single PSRAM controller (state_machine: mem/rw/addr/data_in/data_out/busy) between two CPU-side requesters.
  - Port 0: data/load-store.
  - Port 1: instruction fetch.
- Accepts one request at a time, issues the mem start strobe, tracks the controller's busy, returns read data, and acks the requester.
- Sits between the MIPS246 core memory stage and state_machine. The state_machine is unchanged.

---
 rtl/psram_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_psram_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_arbiter.sv
// rtl/psram_arbiter.sv - two-port request arbiter in front of the PSRAM state_machine controller
//
// Shares one PSRAM controller between the load/store port (port 0) and the
// instruction-fetch port (port 1). Only one access is in flight at a time.
// Every access runs IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> RESP -> IDLE.
//
// Parameters:
//   ISSUE_CYCLES  cycles the mem start strobe is held high per access (1..15)
//   TIMEOUT       cycles allowed in WAIT_BUSY plus WAIT_DONE before the access
//                 is completed with err set (1..65535)
//
// Build option:
//   PSRAM_ARB_RR_EN  defined: round-robin between simultaneous requests
//                    undefined: port 0 has fixed priority
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   pN_req/rw/addr/wdata         requester N: request (held until ack), 1=read,
//                                word address, write data
//   pN_rdata/ack/err             requester N: read data and timeout flag, both
//                                valid with the one-cycle ack pulse
//   mem/rw/addr/data_in          to controller: start strobe, 1=read, address,
//                                write data
//   data_out/busy                from controller: read data, busy
//   owner                        port currently or most recently granted
//   arb_busy                     high whenever the arbiter is not IDLE

module psram_arbiter #(
    parameter int unsigned ISSUE_CYCLES = 1,
    parameter int unsigned TIMEOUT      = 1023
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        p0_req,
    input  logic        p0_rw,
    input  logic [25:0] p0_addr,
    input  logic [15:0] p0_wdata,
    output logic [15:0] p0_rdata,
    output logic        p0_ack,
    output logic        p0_err,

    input  logic        p1_req,
    input  logic        p1_rw,
    input  logic [25:0] p1_addr,
    input  logic [15:0] p1_wdata,
    output logic [15:0] p1_rdata,
    output logic        p1_ack,
    output logic        p1_err,

    output logic        mem,
    output logic        rw,
    output logic [25:0] addr,
    output logic [15:0] data_in,
    input  logic [15:0] data_out,
    input  logic        busy,

    output logic        owner,
    output logic        arb_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    // Terminal values of the two counters; both count from zero.
    localparam logic [3:0]  ISSUE_LAST = 4'(ISSUE_CYCLES - 1);
    localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);

    state_t      state_q;
    logic [3:0]  iss_cnt_q;
    logic [15:0] tmo_cnt_q;

    logic        mem_q;
    logic        rw_q;
    logic [25:0] addr_q;
    logic [15:0] data_in_q;
    logic [15:0] p0_rdata_q;
    logic [15:0] p1_rdata_q;
    logic        p0_ack_q;
    logic        p1_ack_q;
    logic        p0_err_q;
    logic        p1_err_q;
    logic        owner_q;
    logic        arb_busy_q;

    // Port that would be granted if a grant happened this cycle.
    logic        win_d;

    always_comb begin
        win_d = 1'b0;
`ifdef PSRAM_ARB_RR_EN
        // Simultaneous requests go to the port that was not granted last.
        if (p0_req && p1_req) begin
            win_d = ~owner_q;
        end else begin
            win_d = p1_req;
        end
`else
        // Port 0 wins whenever it is requesting.
        win_d = ~p0_req & p1_req;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            iss_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            mem_q      <= 1'b0;
            rw_q       <= 1'b1;
            addr_q     <= '0;
            data_in_q  <= '0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
            p0_ack_q   <= 1'b0;
            p1_ack_q   <= 1'b0;
            p0_err_q   <= 1'b0;
            p1_err_q   <= 1'b0;
            owner_q    <= 1'b1;
            arb_busy_q <= 1'b0;
        end else begin
            // Ack/err are single-cycle pulses; they are raised only on the
            // transition into RESP below.
            p0_ack_q <= 1'b0;
            p1_ack_q <= 1'b0;
            p0_err_q <= 1'b0;
            p1_err_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    // A controller still finishing a dropped access (after a
                    // reset) must not be handed a new start strobe.
                    if (!busy && (p0_req || p1_req)) begin
                        owner_q    <= win_d;
                        rw_q       <= win_d ? p1_rw    : p0_rw;
                        addr_q     <= win_d ? p1_addr  : p0_addr;
                        data_in_q  <= win_d ? p1_wdata : p0_wdata;
                        mem_q      <= 1'b1;
                        iss_cnt_q  <= '0;
                        arb_busy_q <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (iss_cnt_q == ISSUE_LAST) begin
                        mem_q     <= 1'b0;
                        tmo_cnt_q <= '0;
                        state_q   <= S_WAIT_BUSY;
                    end else begin
                        iss_cnt_q <= iss_cnt_q + 4'd1;
                    end
                end

                S_WAIT_BUSY: begin
                    if (busy) begin
                        // The timeout budget spans both wait states.
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                        state_q   <= S_WAIT_DONE;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        p0_ack_q <= ~owner_q;
                        p1_ack_q <= owner_q;
                        p0_err_q <= ~owner_q;
                        p1_err_q <= owner_q;
                        state_q  <= S_RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
                end

                S_WAIT_DONE: begin
                    if (!busy) begin
                        if (rw_q) begin
                            if (owner_q) begin
                                p1_rdata_q <= data_out;
                            end else begin
                                p0_rdata_q <= data_out;
                            end
                        end
                        p0_ack_q <= ~owner_q;
                        p1_ack_q <= owner_q;
                        state_q  <= S_RESP;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        p0_ack_q <= ~owner_q;
                        p1_ack_q <= owner_q;
                        p0_err_q <= ~owner_q;
                        p1_err_q <= owner_q;
                        state_q  <= S_RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
                end

                S_RESP: begin
                    // The requester drops req on this edge, so IDLE sees only
                    // fresh requests.
                    arb_busy_q <= 1'b0;
                    state_q    <= S_IDLE;
                end

                default: begin
                    mem_q      <= 1'b0;
                    arb_busy_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign mem      = mem_q;
    assign rw       = rw_q;
    assign addr     = addr_q;
    assign data_in  = data_in_q;
    assign p0_rdata = p0_rdata_q;
    assign p1_rdata = p1_rdata_q;
    assign p0_ack   = p0_ack_q;
    assign p1_ack   = p1_ack_q;
    assign p0_err   = p0_err_q;
    assign p1_err   = p1_err_q;
    assign owner    = owner_q;
    assign arb_busy = arb_busy_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// tb/tb_psram_arbiter.sv - directed self-checking bench for psram_arbiter

module tb_psram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_rw, p1_req, p1_rw;
    logic [25:0] p0_addr, p1_addr;
    logic [15:0] p0_wdata, p1_wdata;
    logic [15:0] p0_rdata, p1_rdata;
    logic        p0_ack, p0_err, p1_ack, p1_err;
    logic        mem, rw;
    logic [25:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        busy;
    logic        owner, arb_busy;

    always #5 clk = ~clk;

    psram_arbiter #(
        .ISSUE_CYCLES(1),
        .TIMEOUT     (20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .p0_req   (p0_req),
        .p0_rw    (p0_rw),
        .p0_addr  (p0_addr),
        .p0_wdata (p0_wdata),
        .p0_rdata (p0_rdata),
        .p0_ack   (p0_ack),
        .p0_err   (p0_err),
        .p1_req   (p1_req),
        .p1_rw    (p1_rw),
        .p1_addr  (p1_addr),
        .p1_wdata (p1_wdata),
        .p1_rdata (p1_rdata),
        .p1_ack   (p1_ack),
        .p1_err   (p1_err),
        .mem      (mem),
        .rw       (rw),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .busy     (busy),
        .owner    (owner),
        .arb_busy (arb_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse counters, sampled on the falling edge; only this block writes them.
    int mem_hi = 0, p0_acks = 0, p1_acks = 0, err_pulses = 0;
    always @(negedge clk) begin
        if (mem === 1'b1) mem_hi++;
        if (p0_ack === 1'b1) p0_acks++;
        if (p1_ack === 1'b1) p1_acks++;
        if (p0_err === 1'b1 || p1_err === 1'b1) err_pulses++;
    end

    // Controller model: busy rises 2 cycles after the strobe, stays high
    // 5 cycles, and read data appears as busy falls.
    logic        model_en = 1'b1;
    logic [15:0] model_rdata = 16'h0000;
    initial begin
        busy     = 1'b0;
        data_out = 16'h0000;
        forever begin
            @(negedge clk);
            if (mem === 1'b1 && model_en) begin
                @(posedge clk);
                @(posedge clk);
                #1 busy = 1'b1;
                repeat (5) @(posedge clk);
                #1 busy = 1'b0;
                data_out = model_rdata;
            end
        end
    end

    task automatic wait_mem(input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (mem === 1'b1) found = 1'b1;
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    // Returns at the falling edge where the port's ack is seen; lat counts
    // falling edges from the call.
    task automatic wait_ack(input int port, input string tag, output int lat);
        bit found = 1'b0;
        lat = 0;
        for (int i = 1; i <= 200 && !found; i++) begin
            @(negedge clk);
            if (((port == 0) ? p0_ack : p1_ack) === 1'b1) begin
                found = 1'b1;
                lat   = i;
            end
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: run still active, required finish before time limit");
        $fatal(1);
    end

    initial begin
        int lat;
        int m0, a0, b0, e0;
        int order[4];
        int exp_order[4];
        int port;
        bit found;

        rst      = 1'b1;
        p0_req   = 1'b1;
        p1_req   = 1'b1;
        p0_rw    = 1'b0;
        p0_addr  = 26'h0000010;
        p0_wdata = 16'hBEEF;
        p1_rw    = 1'b1;
        p1_addr  = 26'h3FFFFFF;
        p1_wdata = 16'h0000;

        // Reset held 3 cycles with both ports requesting.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem", 32'(mem), 32'd0);
        chk("rst_p0_ack", 32'(p0_ack), 32'd0);
        chk("rst_p1_ack", 32'(p1_ack), 32'd0);
        chk("rst_arb_busy", 32'(arb_busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd1);
        chk("rst_rw", 32'(rw), 32'd1);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_p0_rdata", 32'(p0_rdata), 32'd0);
        m0 = mem_hi; a0 = p0_acks; b0 = p1_acks;
        rst = 1'b0;

        // First grant after reset goes to port 0 (the port 0 write).
        @(negedge clk);
        chk("grant0_owner", 32'(owner), 32'd0);
        chk("grant0_mem", 32'(mem), 32'd1);
        chk("grant0_arb_busy", 32'(arb_busy), 32'd1);
        chk("wr_rw", 32'(rw), 32'd0);
        chk("wr_addr", 32'(addr), 32'h0000010);
        chk("wr_data_in", 32'(data_in), 32'hBEEF);
        p1_req = 1'b0;
        wait_ack(0, "wr_ack_seen", lat);
        chk("wr_latency", 32'(lat), 32'd8);
        chk("wr_err", 32'(p0_err), 32'd0);
        chk("wr_p1_ack", 32'(p1_ack), 32'd0);
        p0_req = 1'b0;
        @(negedge clk);
        chk("wr_mem_cycles", 32'(mem_hi - m0), 32'd1);
        chk("wr_p0_ack_count", 32'(p0_acks - a0), 32'd1);
        chk("wr_p1_ack_count", 32'(p1_acks - b0), 32'd0);
        chk("wr_idle_after", 32'(arb_busy), 32'd0);

        // Port 1 read of the top address.
        model_rdata = 16'hA5A5;
        p1_req = 1'b1;
        wait_mem("rd1_grant_seen");
        chk("rd1_owner", 32'(owner), 32'd1);
        chk("rd1_rw", 32'(rw), 32'd1);
        chk("rd1_addr", 32'(addr), 32'h3FFFFFF);
        wait_ack(1, "rd1_ack_seen", lat);
        chk("rd1_rdata", 32'(p1_rdata), 32'hA5A5);
        chk("rd1_err", 32'(p1_err), 32'd0);
        chk("rd1_p0_rdata_kept", 32'(p0_rdata), 32'd0);
        chk("rd1_latency", 32'(lat), 32'd8);
        p1_req = 1'b0;
        @(negedge clk);

        // Contention: both ports request continuously for 4 transactions.
        p0_rw = 1'b0; p0_addr = 26'h0000020; p0_wdata = 16'h1111;
        p1_rw = 1'b0; p1_addr = 26'h0000030; p1_wdata = 16'h2222;
`ifdef PSRAM_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        b0 = p1_acks;
        p0_req = 1'b1;
        p1_req = 1'b1;
        for (int n = 0; n < 4; n++) begin
            found = 1'b0;
            port  = -1;
            for (int i = 0; i < 100 && !found; i++) begin
                @(negedge clk);
                if (p0_ack === 1'b1) begin
                    found = 1'b1; port = 0;
                end else if (p1_ack === 1'b1) begin
                    found = 1'b1; port = 1;
                end
            end
            chk($sformatf("cont_ack_seen_%0d", n), 32'(found), 32'd1);
            order[n] = port;
            if (n == 3) begin
                p0_req = 1'b0;
                p1_req = 1'b0;
            end else begin
                if (port == 0) p0_req = 1'b0;
                else p1_req = 1'b0;
                @(posedge clk);
                #1;
                p0_req = 1'b1;
                p1_req = 1'b1;
            end
        end
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("cont_grant_%0d", n), 32'(order[n]), 32'(exp_order[n]));
        end
        @(negedge clk);
`ifdef PSRAM_ARB_RR_EN
        chk("cont_p1_ack_count", 32'(p1_acks - b0), 32'd2);
`else
        chk("cont_p1_ack_count", 32'(p1_acks - b0), 32'd0);
`endif

        // Timeout: controller never responds.
        model_en = 1'b0;
        p0_rw = 1'b0; p0_addr = 26'h0000040; p0_wdata = 16'h3333;
        p0_req = 1'b1;
        wait_mem("tmo_grant_seen");
        wait_ack(0, "tmo_ack_seen", lat);
        // One cycle of ISSUE, then 20 cycles of waiting.
        chk("tmo_latency", 32'(lat), 32'd21);
        chk("tmo_err", 32'(p0_err), 32'd1);
        chk("tmo_p1_err", 32'(p1_err), 32'd0);
        p0_req = 1'b0;
        @(negedge clk);
        chk("tmo_idle_after", 32'(arb_busy), 32'd0);
        chk("tmo_ack_one_cycle", 32'(p0_ack), 32'd0);
        model_en = 1'b1;

        // Next request after a timeout proceeds normally.
        model_rdata = 16'h0F0F;
        p1_rw = 1'b1; p1_addr = 26'h0000055;
        p1_req = 1'b1;
        wait_mem("post_tmo_grant_seen");
        wait_ack(1, "post_tmo_ack_seen", lat);
        chk("post_tmo_rdata", 32'(p1_rdata), 32'h0F0F);
        chk("post_tmo_err", 32'(p1_err), 32'd0);
        chk("post_tmo_latency", 32'(lat), 32'd8);
        p1_req = 1'b0;
        @(negedge clk);

        // Reset during WAIT_DONE drops the access without an ack.
        model_rdata = 16'hDEAD;
        p0_rw = 1'b1; p0_addr = 26'h0000100;
        p0_req = 1'b1;
        wait_mem("rstmid_grant_seen");
        repeat (4) @(negedge clk);
        m0 = mem_hi; a0 = p0_acks; b0 = p1_acks; e0 = err_pulses;
        rst = 1'b1;
        p0_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_arb_busy", 32'(arb_busy), 32'd0);
        chk("rstmid_mem", 32'(mem), 32'd0);
        chk("rstmid_owner", 32'(owner), 32'd1);
        repeat (8) @(negedge clk);
        chk("rstmid_p0_acks", 32'(p0_acks - a0), 32'd0);
        chk("rstmid_p1_acks", 32'(p1_acks - b0), 32'd0);
        chk("rstmid_err_pulses", 32'(err_pulses - e0), 32'd0);
        chk("rstmid_mem_pulses", 32'(mem_hi - m0), 32'd0);
        chk("rstmid_p0_rdata", 32'(p0_rdata), 32'd0);

        // Subsequent port 0 read completes.
        model_rdata = 16'h1234;
        p0_rw = 1'b1; p0_addr = 26'h0000200;
        p0_req = 1'b1;
        wait_mem("after_rst_grant_seen");
        chk("after_rst_owner", 32'(owner), 32'd0);
        chk("after_rst_addr", 32'(addr), 32'h0000200);
        wait_ack(0, "after_rst_ack_seen", lat);
        chk("after_rst_rdata", 32'(p0_rdata), 32'h1234);
        chk("after_rst_err", 32'(p0_err), 32'd0);
        chk("after_rst_latency", 32'(lat), 32'd8);
        p0_req = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
